soundweb_packet_streamer: RTL and testbench



---
 rtl/soundweb_packet_streamer.sv | 194 +++++++++++++++++++
 tb/tb_soundweb_packet_streamer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/soundweb_packet_streamer.sv
// Serialises a latched, escaped 29-byte Soundweb packet one byte per tx handshake, then appends ETX.
// Optional SOUNDWEB_ACK_WAIT_EN: after ETX, wait for ACK/NAK, retransmit on NAK/timeout, give up with nak.
module soundweb_packet_streamer
`ifdef SOUNDWEB_ACK_WAIT_EN
#(
  parameter int ACK_TIMEOUT = 1000,
  parameter int MAX_RETRIES = 2
)
`endif
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] packet_0,  packet_1,  packet_2,  packet_3,  packet_4,  packet_5,
  input  logic [7:0] packet_6,  packet_7,  packet_8,  packet_9,  packet_10, packet_11,
  input  logic [7:0] packet_12, packet_13, packet_14, packet_15, packet_16, packet_17,
  input  logic [7:0] packet_18, packet_19, packet_20, packet_21, packet_22, packet_23,
  input  logic [7:0] packet_24, packet_25, packet_26, packet_27, packet_28,
  output logic       busy,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
`ifdef SOUNDWEB_ACK_WAIT_EN
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       nak,
`endif
  output logic       done,
  output logic       err
);

  localparam logic [7:0] STX      = 8'h02;
  localparam logic [7:0] ETX      = 8'h03;
  localparam logic [7:0] ESC      = 8'h1B;
  localparam logic [3:0] SYMBOLS  = 4'd14;
  localparam logic [4:0] LAST_IDX = 5'd28;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_ETX, S_WAIT} state_t;

  state_t     r_state, w_state_nxt;
  logic [4:0] r_idx, w_idx_nxt;
  logic [3:0] r_sym_cnt, w_sym_nxt, w_sym_inc;
  logic       r_esc_pend, w_esc_nxt;
  logic       r_done, w_done_nxt;
  logic       r_err, w_err_nxt;
  logic       w_latch;
  logic [7:0] w_byte;
  logic [7:0] w_pkt [29];
  logic [7:0] r_buf [29];

`ifdef SOUNDWEB_ACK_WAIT_EN
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;
  logic [31:0] r_timer, w_timer_nxt;
  logic [7:0]  r_retry, w_retry_nxt;
  logic        r_nak, w_nak_nxt;
  assign nak = r_nak;
`endif

  assign w_pkt = '{packet_0,  packet_1,  packet_2,  packet_3,  packet_4,  packet_5,
                   packet_6,  packet_7,  packet_8,  packet_9,  packet_10, packet_11,
                   packet_12, packet_13, packet_14, packet_15, packet_16, packet_17,
                   packet_18, packet_19, packet_20, packet_21, packet_22, packet_23,
                   packet_24, packet_25, packet_26, packet_27, packet_28};

  assign w_byte    = r_buf[r_idx];
  assign w_sym_inc = r_sym_cnt + 4'd1;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= 5'd0;
      r_sym_cnt  <= 4'd0;
      r_esc_pend <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef SOUNDWEB_ACK_WAIT_EN
      r_timer    <= 32'd0;
      r_retry    <= 8'd0;
      r_nak      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_sym_cnt  <= w_sym_nxt;
      r_esc_pend <= w_esc_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
`ifdef SOUNDWEB_ACK_WAIT_EN
      r_timer    <= w_timer_nxt;
      r_retry    <= w_retry_nxt;
      r_nak      <= w_nak_nxt;
`endif
    end
  end

  // Packet buffer is pure datapath; only the control state needs reset.
  always_ff @(posedge clk) begin
    if (w_latch) begin
      for (int k = 0; k < 29; k++) r_buf[k] <= w_pkt[k];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_sym_nxt   = r_sym_cnt;
    w_esc_nxt   = r_esc_pend;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_latch     = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
`ifdef SOUNDWEB_ACK_WAIT_EN
    w_timer_nxt = r_timer;
    w_retry_nxt = r_retry;
    w_nak_nxt   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (packet_0 == STX) begin
            w_latch     = 1'b1;
            w_idx_nxt   = 5'd0;
            w_sym_nxt   = 4'd0;
            w_esc_nxt   = 1'b0;
            w_state_nxt = S_SEND;
`ifdef SOUNDWEB_ACK_WAIT_EN
            w_retry_nxt = 8'd0;
`endif
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = w_byte;
        if (tx_ready) begin
          w_idx_nxt = (r_idx == LAST_IDX) ? r_idx : r_idx + 5'd1;
          // STX at idx 0 is framing, not a symbol; an ESC only opens a pair when not itself escaped.
          if (r_idx != 5'd0) begin
            if (w_byte == ESC && !r_esc_pend) begin
              w_esc_nxt = 1'b1;
            end else begin
              w_esc_nxt = 1'b0;
              w_sym_nxt = w_sym_inc;
              if (w_sym_inc == SYMBOLS) w_state_nxt = S_ETX;
            end
          end
          if (r_idx == LAST_IDX) w_state_nxt = S_ETX;
        end
      end
      S_ETX: begin
        tx_valid = 1'b1;
        tx_data  = ETX;
        if (tx_ready) begin
`ifdef SOUNDWEB_ACK_WAIT_EN
          w_state_nxt = S_WAIT;
          w_timer_nxt = 32'd0;
`else
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
`endif
        end
      end
`ifdef SOUNDWEB_ACK_WAIT_EN
      S_WAIT: begin
        w_timer_nxt = r_timer + 32'd1;
        if (rx_valid && rx_data == ACK_BYTE) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if ((rx_valid && rx_data == NAK_BYTE) || r_timer == 32'(ACK_TIMEOUT - 1)) begin
          if (r_retry == 8'(MAX_RETRIES)) begin
            w_nak_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_retry_nxt = r_retry + 8'd1;
            w_idx_nxt   = 5'd0;
            w_sym_nxt   = 4'd0;
            w_esc_nxt   = 1'b0;
            w_state_nxt = S_SEND;
          end
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_soundweb_packet_streamer.sv
// Directed and randomized bench for soundweb_packet_streamer; expected streams come from a symbol-walking model.
module tb_soundweb_packet_streamer;

  typedef logic [7:0] pkt_t [29];

  logic       clk = 1'b0;
  logic       rst, start, tx_ready;
  logic [7:0] pk [29];
  logic       busy, tx_valid, done, err;
  logic [7:0] tx_data;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  soundweb_packet_streamer dut (
    .clk(clk), .rst(rst), .start(start),
    .packet_0(pk[0]),   .packet_1(pk[1]),   .packet_2(pk[2]),   .packet_3(pk[3]),
    .packet_4(pk[4]),   .packet_5(pk[5]),   .packet_6(pk[6]),   .packet_7(pk[7]),
    .packet_8(pk[8]),   .packet_9(pk[9]),   .packet_10(pk[10]), .packet_11(pk[11]),
    .packet_12(pk[12]), .packet_13(pk[13]), .packet_14(pk[14]), .packet_15(pk[15]),
    .packet_16(pk[16]), .packet_17(pk[17]), .packet_18(pk[18]), .packet_19(pk[19]),
    .packet_20(pk[20]), .packet_21(pk[21]), .packet_22(pk[22]), .packet_23(pk[23]),
    .packet_24(pk[24]), .packet_25(pk[25]), .packet_26(pk[26]), .packet_27(pk[27]),
    .packet_28(pk[28]),
    .busy(busy), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: STX, then 14 symbols where an ESC swallows the next byte into the same symbol, then ETX.
  task automatic build_exp(input pkt_t p);
    int i, sym;
    exp_q.delete();
    exp_q.push_back(p[0]);
    i = 1;
    sym = 0;
    while (sym < 14 && i <= 28) begin
      if (p[i] == 8'h1B && i < 28) begin
        exp_q.push_back(p[i]);
        exp_q.push_back(p[i+1]);
        i += 2;
      end else begin
        exp_q.push_back(p[i]);
        i++;
      end
      sym++;
    end
    exp_q.push_back(8'h03);
  endtask

  task automatic gen_pkt(output pkt_t p, input bit wild);
    int i;
    logic [7:0] b;
    for (int k = 0; k < 29; k++) p[k] = 8'h00;
    p[0] = 8'h02;
    if (wild) begin
      for (int k = 1; k < 29; k++) p[k] = ($urandom_range(0, 2) == 0) ? 8'h1B : 8'($urandom);
    end else begin
      i = 1;
      for (int s = 0; s < 14; s++) begin
        if ($urandom_range(0, 3) == 0) begin
          p[i]   = 8'h1B;
          p[i+1] = 8'($urandom) | 8'h80;
          i += 2;
        end else begin
          b = 8'($urandom);
          if (b == 8'h1B) b = 8'h00;
          p[i] = b;
          i++;
        end
      end
    end
  endtask

  // rmode 0: tx_ready always high (except forced stall); 1: random tx_ready.
  task automatic run_pkt(input string tag, input pkt_t p, input int rmode, input int stall_at,
                         input int stall_len, input bit poke, input int explen);
    int n, iter, stalled;
    bit fin, prev_hold, poked;
    logic [7:0] prev_d;
    build_exp(p);
    @(negedge clk);
    pk = p; start = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy_start"}, {31'd0, busy}, 32'd1);
    chk({tag, ".first_stx"}, {24'd0, tx_data}, 32'h02);
    n = 0; iter = 0; stalled = 0; fin = 0; prev_hold = 0; poked = 0; prev_d = 8'h00;
    while (!fin && iter < 600) begin
      if (prev_hold) begin
        chk({tag, ".hold_valid"}, {31'd0, tx_valid}, 32'd1);
        chk({tag, ".hold_data"}, {24'd0, tx_data}, {24'd0, prev_d});
      end
      if (!tx_valid) chk({tag, ".valid_drop"}, {31'd0, tx_valid}, 32'd1);
      if (err) chk({tag, ".spurious_err"}, {31'd0, err}, 32'd0);
      if (done) chk({tag, ".early_done"}, {31'd0, done}, 32'd0);
      if (poke && n == 5 && !poked) begin
        start = 1'b1;
        for (int k = 1; k < 29; k++) pk[k] = 8'($urandom);
        poked = 1;
      end else begin
        start = 1'b0;
      end
      if (stall_at == n && stalled < stall_len) begin
        tx_ready = 1'b0;
        stalled++;
      end else begin
        tx_ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
      if (tx_valid && tx_ready) begin
        if (n < exp_q.size()) chk($sformatf("%s.byte%0d", tag, n), {24'd0, tx_data}, {24'd0, exp_q[n]});
        n++;
        if (n == exp_q.size()) fin = 1;
      end
      prev_hold = tx_valid && !tx_ready;
      prev_d = tx_data;
      iter++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, ".count"}, n, exp_q.size());
    if (explen != 0) chk({tag, ".len"}, n, explen);
    if (rmode == 0 && stall_len == 0) chk({tag, ".cycles"}, iter, exp_q.size());
    chk({tag, ".done"}, {31'd0, done}, 32'd1);
    chk({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, ".valid_end"}, {31'd0, tx_valid}, 32'd0);
    @(negedge clk);
    chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    pkt_t p;
    int seen;
    rst = 1'b1; start = 1'b0; tx_ready = 1'b0;
    for (int k = 0; k < 29; k++) pk[k] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.valid", {31'd0, tx_valid}, 32'd0);
    chk("rst.data", {24'd0, tx_data}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.err", {31'd0, err}, 32'd0);

    for (int k = 0; k < 29; k++) p[k] = 8'h00;
    p[0] = 8'h02;
    run_pkt("plain", p, 0, -1, 0, 0, 16);

    p[1] = 8'h1B; p[2] = 8'h82; p[15] = 8'h1B; p[16] = 8'h82;
    run_pkt("esc_cmd", p, 0, -1, 0, 0, 18);

    for (int k = 1; k < 29; k += 2) begin p[k] = 8'h1B; p[k+1] = 8'h9B; end
    run_pkt("maxlen", p, 0, -1, 0, 0, 30);

    gen_pkt(p, 0);
    run_pkt("stall", p, 0, 3, 5, 0, 0);

    gen_pkt(p, 0);
    run_pkt("busy_start", p, 0, -1, 0, 1, 0);

    @(negedge clk);
    pk[0] = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("reject.err", {31'd0, err}, 32'd1);
    chk("reject.valid", {31'd0, tx_valid}, 32'd0);
    chk("reject.busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("reject.err_pulse", {31'd0, err}, 32'd0);

    pk[0] = 8'h02; rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start.busy", {31'd0, busy}, 32'd0);
    chk("rst_start.valid", {31'd0, tx_valid}, 32'd0);

    gen_pkt(p, 0);
    pk = p; start = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.valid", {31'd0, tx_valid}, 32'd0);
    chk("midrst.busy", {31'd0, busy}, 32'd0);
    chk("midrst.data", {24'd0, tx_data}, 32'd0);
    chk("midrst.done", {31'd0, done}, 32'd0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_valid || done || busy) seen++;
    end
    chk("midrst.quiet", seen, 0);
    run_pkt("after_rst", p, 0, -1, 0, 0, 0);

    for (int t = 0; t < 24; t++) begin
      gen_pkt(p, (t % 4) == 3);
      run_pkt($sformatf("rand%0d", t), p, t % 2, $urandom_range(0, 12), $urandom_range(0, 3), (t % 5) == 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
